// File: rtl/de_scoreboard_stage.sv
// Decode stage: unpacks the FE latch, decodes RV32I fields and immediates, tracks
// in-flight register writers per register, stalls fetch on hazards, and issues the DE latch.
module de_scoreboard_stage #(
    parameter int unsigned FE_W        = 97,
    parameter int unsigned SB_CNT_BITS = 2,
    parameter int unsigned NREGS       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [FE_W-1:0]  fe_latch_in,
    input  logic             br_mispred_agex,
    input  logic             wb_retire_valid,
    input  logic [4:0]       wb_retire_rd,
    output logic             stall_to_fe,
    output logic             de_valid,
    output logic [31:0]      de_inst,
    output logic [31:0]      de_pc,
    output logic [31:0]      de_pcplus,
    output logic [31:0]      de_imm,
    output logic [4:0]       de_rd,
    output logic [4:0]       de_rs1,
    output logic [4:0]       de_rs2,
    output logic             de_wr_reg,
    output logic [2:0]       de_op_class,
    output logic [NREGS-1:0] sb_busy_vec
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam logic [SB_CNT_BITS-1:0] CNT_MAX = '1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        CLS_ALU_R  = 3'd0,
        CLS_ALU_I  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_UPPER  = 3'd7
    } op_class_e;

    // FE latch unpack
    logic            w_fe_valid;
    logic [XLEN-1:0] w_inst;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pcplus;
    logic [6:0]      w_opcode;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;

    assign w_fe_valid = fe_latch_in[96];
    assign w_inst     = fe_latch_in[95:64];
    assign w_pc       = fe_latch_in[63:32];
    assign w_pcplus   = fe_latch_in[31:0];
    assign w_opcode   = w_inst[6:0];
    assign w_rd       = w_inst[11:7];
    assign w_rs1      = w_inst[19:15];
    assign w_rs2      = w_inst[24:20];

    // Immediate formats, all sign-extended from inst[31]
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

    logic            w_decodable;
    op_class_e       w_cls;
    logic            w_use_rs1_raw;
    logic            w_use_rs2_raw;
    logic            w_wr_raw;
    logic [XLEN-1:0] w_imm;

    // Opcode decode: class, register usage and immediate selection
    always_comb begin
        w_decodable   = 1'b0;
        w_cls         = CLS_ALU_R;
        w_use_rs1_raw = 1'b0;
        w_use_rs2_raw = 1'b0;
        w_wr_raw      = 1'b0;
        w_imm         = '0;
        case (w_opcode)
            OPC_OP: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_ALU_R;
                w_use_rs1_raw = 1'b1;
                w_use_rs2_raw = 1'b1;
                w_wr_raw      = 1'b1;
            end
            OPC_OP_IMM: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_ALU_I;
                w_use_rs1_raw = 1'b1;
                w_wr_raw      = 1'b1;
                w_imm         = w_imm_i;
            end
            OPC_LOAD: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_LOAD;
                w_use_rs1_raw = 1'b1;
                w_wr_raw      = 1'b1;
                w_imm         = w_imm_i;
            end
            OPC_STORE: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_STORE;
                w_use_rs1_raw = 1'b1;
                w_use_rs2_raw = 1'b1;
                w_imm         = w_imm_s;
            end
            OPC_BRANCH: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_BRANCH;
                w_use_rs1_raw = 1'b1;
                w_use_rs2_raw = 1'b1;
                w_imm         = w_imm_b;
            end
            OPC_JAL: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_JAL;
                w_wr_raw      = 1'b1;
                w_imm         = w_imm_j;
            end
            OPC_JALR: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_JALR;
                w_use_rs1_raw = 1'b1;
                w_wr_raw      = 1'b1;
                w_imm         = w_imm_i;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_decodable   = 1'b1;
                w_cls         = CLS_UPPER;
                w_wr_raw      = 1'b1;
                w_imm         = w_imm_u;
            end
            default: begin
                w_decodable   = 1'b0;
            end
        endcase
    end

    // x0 is never a dependency nor a tracked destination
    logic w_use_rs1;
    logic w_use_rs2;
    logic w_wr;

    assign w_use_rs1 = w_use_rs1_raw && (w_rs1 != '0);
    assign w_use_rs2 = w_use_rs2_raw && (w_rs2 != '0);
    assign w_wr      = w_wr_raw && (w_rd != '0);

    // Per-register in-flight writer counters
    logic [SB_CNT_BITS-1:0] r_cnt [NREGS];
    logic [NREGS-1:0]       w_retire_hit;
    logic [NREGS-1:0]       w_eff_busy;
    logic [NREGS-1:0]       w_inc_vec;
    logic                   w_issue;

    // A retire this cycle already satisfies a dependent read (write-first regfile)
    always_comb begin
        w_retire_hit = '0;
        w_eff_busy   = '0;
        w_inc_vec    = '0;
        sb_busy_vec  = '0;
        for (int r = 1; r < int'(NREGS); r++) begin
            w_retire_hit[r] = wb_retire_valid && (wb_retire_rd == REG_W'(r));
            w_eff_busy[r]   = (r_cnt[r] != '0) &&
                              !(w_retire_hit[r] && (r_cnt[r] == SB_CNT_BITS'(1)));
            w_inc_vec[r]    = w_issue && w_wr && (w_rd == REG_W'(r));
            sb_busy_vec[r]  = (r_cnt[r] != '0);
        end
    end

    logic w_raw;
    logic w_waw_full;

    assign w_raw       = (w_use_rs1 && w_eff_busy[w_rs1]) || (w_use_rs2 && w_eff_busy[w_rs2]);
    assign w_waw_full  = w_wr && (r_cnt[w_rd] == CNT_MAX);
    assign stall_to_fe = w_fe_valid && w_decodable && (w_raw || w_waw_full) &&
                         !br_mispred_agex && reset_n;
    assign w_issue     = w_fe_valid && w_decodable && !stall_to_fe && !br_mispred_agex;

    // Counter update; simultaneous issue and retire on one register cancel out
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int r = 1; r < int'(NREGS); r++) begin
                if (w_inc_vec[r] && !w_retire_hit[r] && (r_cnt[r] != CNT_MAX)) begin
                    r_cnt[r] <= r_cnt[r] + SB_CNT_BITS'(1);
                end else if (w_retire_hit[r] && !w_inc_vec[r] && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - SB_CNT_BITS'(1);
                end
            end
        end
    end

    // DE latch: decoded fields on issue, all-zero bubble otherwise
    always_ff @(posedge clk) begin
        if (!reset_n || !w_issue) begin
            de_valid    <= 1'b0;
            de_inst     <= '0;
            de_pc       <= '0;
            de_pcplus   <= '0;
            de_imm      <= '0;
            de_rd       <= '0;
            de_rs1      <= '0;
            de_rs2      <= '0;
            de_wr_reg   <= 1'b0;
            de_op_class <= '0;
        end else begin
            de_valid    <= 1'b1;
            de_inst     <= w_inst;
            de_pc       <= w_pc;
            de_pcplus   <= w_pcplus;
            de_imm      <= w_imm;
            de_rd       <= w_rd;
            de_rs1      <= w_rs1;
            de_rs2      <= w_rs2;
            de_wr_reg   <= w_wr;
            de_op_class <= w_cls;
        end
    end

endmodule

// File: tb/tb_de_scoreboard_stage.sv
// Bench for de_scoreboard_stage: directed instruction sequences checked every cycle
// against a behavioural scoreboard model, plus hand-computed literal expectations.
module tb_de_scoreboard_stage;

    logic        clk;
    logic        reset_n;
    logic [96:0] fe_latch_in;
    logic        br_mispred_agex;
    logic        wb_retire_valid;
    logic [4:0]  wb_retire_rd;
    logic        stall_to_fe;
    logic        de_valid;
    logic [31:0] de_inst;
    logic [31:0] de_pc;
    logic [31:0] de_pcplus;
    logic [31:0] de_imm;
    logic [4:0]  de_rd;
    logic [4:0]  de_rs1;
    logic [4:0]  de_rs2;
    logic        de_wr_reg;
    logic [2:0]  de_op_class;
    logic [31:0] sb_busy_vec;

    de_scoreboard_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fe_latch_in     (fe_latch_in),
        .br_mispred_agex (br_mispred_agex),
        .wb_retire_valid (wb_retire_valid),
        .wb_retire_rd    (wb_retire_rd),
        .stall_to_fe     (stall_to_fe),
        .de_valid        (de_valid),
        .de_inst         (de_inst),
        .de_pc           (de_pc),
        .de_pcplus       (de_pcplus),
        .de_imm          (de_imm),
        .de_rd           (de_rd),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_wr_reg       (de_wr_reg),
        .de_op_class     (de_op_class),
        .sb_busy_vec     (sb_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        ok;
        logic [2:0]  cls;
        logic        u1;
        logic        u2;
        logic        wr;
        logic [31:0] imm;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcp;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wr;
        logic [2:0]  cls;
    } de_t;

    int  mcnt [32];
    de_t exp_de;

    function automatic dec_t dec(input logic [31:0] i);
        dec_t d;
        logic signed [31:0] s;
        s = $signed(i);
        d = '0;
        case (i[6:0])
            7'h33: begin d.ok = 1; d.cls = 3'd0; d.u1 = 1; d.u2 = 1; d.wr = 1; end
            7'h13: begin d.ok = 1; d.cls = 3'd1; d.u1 = 1; d.wr = 1; d.imm = 32'(s >>> 20); end
            7'h03: begin d.ok = 1; d.cls = 3'd2; d.u1 = 1; d.wr = 1; d.imm = 32'(s >>> 20); end
            7'h23: begin
                d.ok = 1; d.cls = 3'd3; d.u1 = 1; d.u2 = 1;
                d.imm = 32'((s >>> 25) << 5) | 32'(i[11:7]);
            end
            7'h63: begin
                d.ok = 1; d.cls = 3'd4; d.u1 = 1; d.u2 = 1;
                d.imm = 32'((s >>> 31) << 12) | (32'(i[7]) << 11) |
                        (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            end
            7'h6F: begin
                d.ok = 1; d.cls = 3'd5; d.wr = 1;
                d.imm = 32'((s >>> 31) << 20) | (32'(i[19:12]) << 12) |
                        (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h67: begin d.ok = 1; d.cls = 3'd6; d.u1 = 1; d.wr = 1; d.imm = 32'(s >>> 20); end
            7'h37, 7'h17: begin d.ok = 1; d.cls = 3'd7; d.wr = 1; d.imm = i & 32'hFFFFF000; end
            default: ;
        endcase
        if (i[19:15] == 5'd0) d.u1 = 0;
        if (i[24:20] == 5'd0) d.u2 = 0;
        if (i[11:7]  == 5'd0) d.wr = 0;
        return d;
    endfunction

    function automatic bit m_busy_eff(input int r);
        int c;
        c = mcnt[r];
        if (wb_retire_valid && int'(wb_retire_rd) == r && r != 0 && c > 0) c--;
        return c != 0;
    endfunction

    function automatic bit m_stall();
        dec_t d;
        bit   raw;
        bit   waw;
        d = dec(fe_latch_in[95:64]);
        if (!fe_latch_in[96] || !d.ok) return 1'b0;
        raw = (d.u1 && m_busy_eff(int'(fe_latch_in[83:79]))) ||
              (d.u2 && m_busy_eff(int'(fe_latch_in[88:84])));
        waw = d.wr && mcnt[int'(fe_latch_in[75:71])] == 3;
        return (raw || waw) && !br_mispred_agex && reset_n;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int r = 0; r < 32; r++) v[r] = (mcnt[r] != 0);
        return v;
    endfunction

    // Model state advance on each rising edge
    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        exp_de = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                for (int r = 0; r < 32; r++) mcnt[r] = 0;
                exp_de = '0;
            end else begin
                dec_t  d;
                bit    issue;
                int    inc_r;
                int    dec_r;
                logic [31:0] inst;
                inst  = fe_latch_in[95:64];
                d     = dec(inst);
                issue = fe_latch_in[96] && d.ok && !m_stall() && !br_mispred_agex;
                inc_r = (issue && d.wr) ? int'(inst[11:7]) : -1;
                dec_r = (wb_retire_valid && wb_retire_rd != 5'd0) ? int'(wb_retire_rd) : -1;
                if (issue) begin
                    exp_de = '{v: 1'b1, inst: inst, pc: fe_latch_in[63:32], pcp: fe_latch_in[31:0],
                               imm: d.imm, rd: inst[11:7], rs1: inst[19:15], rs2: inst[24:20],
                               wr: d.wr, cls: d.cls};
                end else begin
                    exp_de = '0;
                end
                if (!(inc_r >= 0 && inc_r == dec_r)) begin
                    if (inc_r >= 0 && mcnt[inc_r] < 3) mcnt[inc_r]++;
                    if (dec_r >= 0 && mcnt[dec_r] > 0) mcnt[dec_r]--;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_stall",    32'(stall_to_fe), 32'(m_stall()));
                chk("m_busy",     sb_busy_vec,      m_busy_vec());
                chk("m_de_valid", 32'(de_valid),    32'(exp_de.v));
                chk("m_de_inst",  de_inst,          exp_de.inst);
                chk("m_de_pc",    de_pc,            exp_de.pc);
                chk("m_de_pcplus",de_pcplus,        exp_de.pcp);
                chk("m_de_imm",   de_imm,           exp_de.imm);
                chk("m_de_rd",    32'(de_rd),       32'(exp_de.rd));
                chk("m_de_rs1",   32'(de_rs1),      32'(exp_de.rs1));
                chk("m_de_rs2",   32'(de_rs2),      32'(exp_de.rs2));
                chk("m_de_wr",    32'(de_wr_reg),   32'(exp_de.wr));
                chk("m_de_cls",   32'(de_op_class), 32'(exp_de.cls));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic mis, input logic rv, input logic [4:0] rrd, input logic rst_n);
        @(posedge clk);
        #1;
        fe_latch_in     = {v, inst, pc, pc + 32'd4};
        br_mispred_agex = mis;
        wb_retire_valid = rv;
        wb_retire_rd    = rrd;
        reset_n         = rst_n;
    endtask

    task automatic go(input logic [31:0] inst, input logic [31:0] pc);
        drive(1'b1, inst, pc, 1'b0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic bub();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    endtask

    task automatic ret(input logic [4:0] rd);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, rd, 1'b1);
    endtask

    initial begin
        reset_n         = 1'b0;
        fe_latch_in     = '0;
        br_mispred_agex = 1'b0;
        wb_retire_valid = 1'b0;
        wb_retire_rd    = 5'd0;

        // Reset
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall_to_fe), 32'd0);
        chk("rst_busy",  sb_busy_vec,      32'd0);
        chk("rst_valid", 32'(de_valid),    32'd0);

        // RAW stall with same-cycle retire bypass
        go(32'h00100293, 32'h100);
        @(negedge clk); chk("raw_first_nostall", 32'(stall_to_fe), 32'd0);
        go(32'h00528333, 32'h104);
        @(negedge clk);
        chk("raw_addi_valid", 32'(de_valid),  32'd1);
        chk("raw_addi_wr",    32'(de_wr_reg), 32'd1);
        chk("raw_busy5",      sb_busy_vec,    32'h0000_0020);
        chk("raw_stall",      32'(stall_to_fe), 32'd1);
        for (int k = 0; k < 2; k++) begin
            go(32'h00528333, 32'h104);
            @(negedge clk);
            chk("raw_hold_stall", 32'(stall_to_fe), 32'd1);
            chk("raw_hold_bubble", 32'(de_valid), 32'd0);
        end
        drive(1'b1, 32'h00528333, 32'h104, 1'b0, 1'b1, 5'd5, 1'b1);
        @(negedge clk); chk("raw_bypass_nostall", 32'(stall_to_fe), 32'd0);
        bub();
        @(negedge clk);
        chk("raw_add_valid", 32'(de_valid), 32'd1);
        chk("raw_add_inst",  de_inst,       32'h00528333);
        chk("raw_busy6",     sb_busy_vec,   32'h0000_0040);
        ret(5'd6);
        bub();

        // x0 handling
        go(32'h00500013, 32'h200);
        @(negedge clk); chk("x0_nostall", 32'(stall_to_fe), 32'd0);
        go(32'h000000B3, 32'h204);
        @(negedge clk);
        chk("x0_wr",    32'(de_wr_reg), 32'd0);
        chk("x0_imm",   de_imm,         32'd5);
        chk("x0_busy",  sb_busy_vec,    32'd0);
        chk("x0_stall", 32'(stall_to_fe), 32'd0);
        bub();
        @(negedge clk); chk("x0_add_rd", 32'(de_rd), 32'd1);
        ret(5'd1);
        bub();

        // WAW saturation on x7
        for (int k = 0; k < 3; k++) go(32'h00100393, 32'h300);
        go(32'h00100393, 32'h300);
        @(negedge clk); chk("waw_full_stall", 32'(stall_to_fe), 32'd1);
        drive(1'b1, 32'h00100393, 32'h300, 1'b0, 1'b1, 5'd7, 1'b1);
        @(negedge clk); chk("waw_retire_still_full", 32'(stall_to_fe), 32'd1);
        go(32'h00100393, 32'h300);
        @(negedge clk); chk("waw_release", 32'(stall_to_fe), 32'd0);
        bub();
        @(negedge clk);
        chk("waw_issue_valid", 32'(de_valid), 32'd1);
        chk("waw_busy7",       sb_busy_vec,   32'h0000_0080);
        for (int k = 0; k < 4; k++) ret(5'd7);
        bub();
        @(negedge clk); chk("waw_drained_sat0", sb_busy_vec, 32'd0);

        // Immediate decode
        go(32'hFE000EE3, 32'h400);
        go(32'h123451B7, 32'h404);
        @(negedge clk);
        chk("beq_cls", 32'(de_op_class), 32'd4);
        chk("beq_imm", de_imm,           32'hFFFF_FFFC);
        go(32'h00512423, 32'h408);
        @(negedge clk);
        chk("lui_cls", 32'(de_op_class), 32'd7);
        chk("lui_imm", de_imm,           32'h1234_5000);
        go(32'h010000EF, 32'h40C);
        @(negedge clk);
        chk("sw_cls", 32'(de_op_class), 32'd3);
        chk("sw_wr",  32'(de_wr_reg),   32'd0);
        chk("sw_imm", de_imm,           32'd8);
        go(32'hFFFF_FFFF, 32'h410);
        @(negedge clk);
        chk("jal_imm",    de_imm,           32'd16);
        chk("jal_pcplus", de_pcplus,        32'h410);
        chk("bad_nostall", 32'(stall_to_fe), 32'd0);
        bub();
        @(negedge clk); chk("bad_not_issued", 32'(de_valid), 32'd0);
        ret(5'd3);
        ret(5'd1);
        bub();

        // Mispredict squash
        go(32'h00100293, 32'h500);
        drive(1'b1, 32'h00528333, 32'h504, 1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clk); chk("mis_hazard_nostall", 32'(stall_to_fe), 32'd0);
        drive(1'b1, 32'h00100493, 32'h508, 1'b1, 1'b0, 5'd0, 1'b1);
        @(negedge clk); chk("mis_add_squashed", 32'(de_valid), 32'd0);
        bub();
        @(negedge clk);
        chk("mis_addi_squashed", 32'(de_valid), 32'd0);
        chk("mis_busy",          sb_busy_vec,   32'h0000_0020);

        // Reset mid-operation with x5 busy; retire during reset is ignored
        drive(1'b1, 32'h00528333, 32'h504, 1'b0, 1'b1, 5'd9, 1'b0);
        @(negedge clk); chk("rst_mid_stall", 32'(stall_to_fe), 32'd0);
        go(32'h00528333, 32'h504);
        @(negedge clk);
        chk("rst_mid_busy",  sb_busy_vec,     32'd0);
        chk("rst_mid_valid", 32'(de_valid),   32'd0);
        chk("rst_mid_inst",  de_inst,         32'd0);
        chk("rst_mid_pc",    de_pc,           32'd0);
        chk("rst_mid_nostall", 32'(stall_to_fe), 32'd0);
        bub();
        @(negedge clk);
        chk("post_rst_issue", 32'(de_valid), 32'd1);
        chk("post_rst_inst",  de_inst,       32'h00528333);
        bub();
        @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/de_scoreboard_stage.md
Name: de_scoreboard_stage

Overview:
- Decode-side consumer of the fetch-stage pipeline latch.
- Unpacks the FE latch and decodes RV32I fields and immediates.
- Tracks in-flight register writers with a per-register scoreboard and drives the stall signal back to fetch.
- Issues a registered DE latch toward AGEX, squashes on AGEX branch misprediction, and releases scoreboard entries on WB retire.

Parameters:
- FE_W, 97, FE latch width: {valid[96], inst[95:64], pc[63:32], pcplus[31:0]}
- SB_CNT_BITS, 2, width of each per-register in-flight writer counter
- NREGS, 32, architectural register count (x0 hardwired zero)

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  synchronous active-low reset, sampled on rising clk
- fe_latch_in  input  97  FE latch contents (layout above)
- br_mispred_agex  input  1  AGEX branch mispredict; squash the DE-resident instruction
- wb_retire_valid  input  1  WB stage retiring a register-writing instruction this cycle
- wb_retire_rd  input  5  destination register of the retiring instruction
- stall_to_fe  output  1  combinational; bit 0 of from_DE_to_FE; FE holds PC and latch when 1
- de_valid  output  1  DE latch valid
- de_inst  output  32  instruction
- de_pc  output  32  instruction PC
- de_pcplus  output  32  PC+4
- de_imm  output  32  sign-extended immediate
- de_rd, de_rs1, de_rs2  output  5 each  register specifiers
- de_wr_reg  output  1  instruction writes rd (rd!=0)
- de_op_class  output  3  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 UPPER (LUI/AUIPC)
- sb_busy_vec  output  32  bit i = (cnt[i]!=0), for debug and verification

Behaviour:
- Reset (reset_n=0 at posedge):
  - All counters clear to 0 and all DE latch outputs clear to 0.
  - stall_to_fe is forced to 0 while reset_n=0.
  - Reset mid-operation discards all in-flight state; retires arriving during reset are ignored.
- Decode (combinational, from fe_latch_in):
  - Opcode determines op_class, use_rs1, use_rs2, wr.
  - Immediate formats: I (ALU_I/LOAD/JALR), S, B, U, J, sign-extended to 32 bits. ALU_R immediate = 0.
  - Unrecognised opcode: treated as a bubble. Not issued, no stall, no scoreboard change.
  - use_rs for x0 is forced to 0; wr for rd=0 is forced to 0.
- Hazard check (combinational):
  - eff_cnt[r] = cnt[r] minus 1 if (wb_retire_valid && wb_retire_rd==r && r!=0). Same-cycle retire bypasses, matching a write-first register file.
  - raw = (use_rs1 && eff_cnt[rs1]!=0) || (use_rs2 && eff_cnt[rs2]!=0).
  - waw_full = wr && cnt[rd]==2^SB_CNT_BITS-1.
  - stall_to_fe = fe_valid && decodable && (raw || waw_full) && !br_mispred_agex && reset_n.
- Issue:
  - issue = fe_valid && decodable && !stall_to_fe && !br_mispred_agex.
  - On posedge, the DE latch loads the decoded fields with de_valid=issue.
  - Otherwise the DE latch loads all zeros (bubble). No backpressure from AGEX; latency FE latch -> DE latch = 1 cycle.
- Scoreboard update (posedge):
  - cnt[rd] += (issue && wr).
  - cnt[wb_retire_rd] -= (wb_retire_valid && wb_retire_rd!=0).
  - Same register incremented and decremented in the same cycle: net unchanged.
  - Decrement at 0 saturates at 0 (protocol error; no wrap).
  - cnt[0] is always 0.
- Mispredict:
  - br_mispred_agex=1 forces a bubble into the DE latch and inhibits increments.
  - Retire decrements still apply.
  - stall_to_fe=0 so FE redirect takes precedence.
- Stall state:
  - While stalled, FE holds fe_latch_in stable and the DE latch emits bubbles.
  - Issue occurs in the first cycle the hazard clears.

Test Plan:
- RAW stall:
  - Stimulus: FE presents addi x5,x0,1 (0x00100293), then add x6,x5,x5 (0x00528333).
  - Required: first issues with de_wr_reg=1 and sb_busy_vec[5]=1.
  - Second holds stall_to_fe=1 and de_valid=0 until wb_retire_valid with rd=5; it issues in that same cycle (bypass) and appears in the DE latch next cycle.
- x0 handling:
  - Stimulus: addi x0,x0,5 then add x1,x0,x0.
  - Required: no stall, de_wr_reg=0, sb_busy_vec stays 0.
- WAW saturation:
  - Stimulus: three back-to-back writes of x7 with no retire, then a fourth.
  - Required: cnt[7]=3 and stall_to_fe=1 on the fourth.
  - After one retire of x7, the fourth issues and cnt stays 3 (increment and decrement net 0 if same cycle).
- Mispredict squash:
  - Stimulus: valid addi x9 in the FE latch with br_mispred_agex=1.
  - Required: de_valid=0 next cycle, sb_busy_vec[9]=0, stall_to_fe=0 even if a hazard exists.
- Immediate decode:
  - beq with imm=-4 (0xFE000EE3) -> de_op_class=4, de_imm=0xFFFFFFFC.
  - lui x3,0x12345 -> class 7, de_imm=0x12345000.
  - sw -> class 3, de_wr_reg=0.
- Reset mid-operation:
  - Stimulus: set x5 busy, drive reset_n=0 for 1 cycle.
  - Required: sb_busy_vec=0, all DE outputs 0, stall_to_fe=0.
  - A subsequent dependent instruction on x5 issues without stall.
